// File: rtl/uart_cmd_responder.sv
// -----------------------------------------------------------------------------
// uart_cmd_responder
//
// Target end of a host-driven UART register-access link. Received bytes are
// decoded into a small command protocol, a single-beat access is made on an
// 8-bit register bus, and a one-byte response goes back to the transmitter.
//
//   'W' (0x57), addr, data  -> bus write, response 0x06 (ACK)
//   'R' (0x52), addr        -> bus read,  response = read byte
//   any other first byte    -> response 0x15 (NAK), no bus access
//
// A partial command that sees no further byte for c_timeout_bytes character
// times is abandoned silently (timeout_tick_o pulses).
//
// Ports
//   clk_i           system clock, rising edge
//   rstn_i          asynchronous active-low reset
//   rx_dout_i       received byte, valid while rx_done_tick_i=1
//   rx_done_tick_i  one-cycle pulse per received byte
//   tx_din_o        response byte, stable from SEND entry until next response
//   tx_start_o      one-cycle transmit request
//   tx_active_i     transmitter busy
//   tx_done_tick_i  one-cycle pulse at end of a transmitted frame
//   bus_addr_o      register address (holds last latched value)
//   bus_wdata_o     write data (holds last latched value)
//   bus_we_o        one-cycle write strobe
//   bus_re_o        one-cycle read strobe
//   bus_rdata_i     read data, valid the cycle after bus_re_o
//   timeout_tick_o  one-cycle pulse when a partial command is abandoned
//   overrun_o       sticky: a byte arrived while busy and was dropped
//   dbg_state_o     current FSM state (IDLE=0 .. WAIT_TX=7, see localparams)
//
// Handshakes: rx_done_tick_i qualifies rx_dout_i for exactly that cycle and is
// never back-pressured (a byte arriving while busy is dropped and flagged).
// tx_start_o is raised only when tx_active_i=0 and for a single cycle; the
// response is then considered owned by the transmitter until tx_done_tick_i.
// bus_we_o / bus_re_o are single-cycle strobes with address/data stable in
// that cycle; bus_rdata_i is sampled exactly one cycle after bus_re_o.
// -----------------------------------------------------------------------------
module uart_cmd_responder #(
    parameter int c_clkfreq       = 100_000_000,
    parameter int c_baudrate      = 10_000_000,
    parameter int c_timeout_bytes = 4
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] rx_dout_i,
    input  logic       rx_done_tick_i,
    output logic [7:0] tx_din_o,
    output logic       tx_start_o,
    input  logic       tx_active_i,
    input  logic       tx_done_tick_i,
    output logic [7:0] bus_addr_o,
    output logic [7:0] bus_wdata_o,
    output logic       bus_we_o,
    output logic       bus_re_o,
    input  logic [7:0] bus_rdata_i,
    output logic       timeout_tick_o,
    output logic       overrun_o,
    output logic [2:0] dbg_state_o
);

    // One character is 11 bit times (start, 8 data, parity/stop margin).
    localparam int c_limit = c_timeout_bytes * 11 * (c_clkfreq / c_baudrate);
    localparam int c_cnt_w = $clog2(c_limit + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_limit - 1);

    localparam logic [7:0] c_cmd_write = 8'h57;
    localparam logic [7:0] c_cmd_read  = 8'h52;
    localparam logic [7:0] c_rsp_ack   = 8'h06;
    localparam logic [7:0] c_rsp_nak   = 8'h15;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_ADDR = 3'd1;
    localparam logic [2:0] S_GET_DATA = 3'd2;
    localparam logic [2:0] S_BUS_WR   = 3'd3;
    localparam logic [2:0] S_BUS_RD   = 3'd4;
    localparam logic [2:0] S_BUS_CAP  = 3'd5;
    localparam logic [2:0] S_SEND     = 3'd6;
    localparam logic [2:0] S_WAIT_TX  = 3'd7;

    logic [2:0]         r_state;
    logic               r_write;
    logic [7:0]         r_addr;
    logic [7:0]         r_wdata;
    logic [7:0]         r_txd;
    logic               r_timeout;
    logic               r_overrun;
    logic [c_cnt_w-1:0] r_cnt;

    logic w_in_get;
    logic w_busy;
    logic w_expired;

    assign w_in_get = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
    // Any state after the last command byte and before the response frame
    // finishes cannot accept a byte.
    assign w_busy   = (r_state == S_BUS_WR) || (r_state == S_BUS_RD) ||
                      (r_state == S_BUS_CAP) || (r_state == S_SEND) ||
                      (r_state == S_WAIT_TX);
    // A byte in the expiry cycle wins over the timeout.
    assign w_expired = w_in_get && !rx_done_tick_i && (r_cnt == c_cnt_last);

    // r_cnt holds the number of cycles since the last received byte, so the
    // abandon pulse lands exactly c_limit cycles after that byte's tick.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (rx_done_tick_i) begin
            r_cnt <= c_cnt_w'(1);
        end else if (w_in_get) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= S_IDLE;
            r_write   <= 1'b0;
            r_addr    <= 8'h00;
            r_wdata   <= 8'h00;
            r_txd     <= 8'h00;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (rx_done_tick_i && w_busy) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (rx_done_tick_i) begin
                        if (rx_dout_i == c_cmd_write) begin
                            r_write <= 1'b1;
                            r_state <= S_GET_ADDR;
                        end else if (rx_dout_i == c_cmd_read) begin
                            r_write <= 1'b0;
                            r_state <= S_GET_ADDR;
                        end else begin
                            r_txd   <= c_rsp_nak;
                            r_state <= S_SEND;
                        end
                    end
                end

                S_GET_ADDR: begin
                    if (rx_done_tick_i) begin
                        r_addr  <= rx_dout_i;
                        r_state <= r_write ? S_GET_DATA : S_BUS_RD;
                    end else if (w_expired) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end

                S_GET_DATA: begin
                    if (rx_done_tick_i) begin
                        r_wdata <= rx_dout_i;
                        r_state <= S_BUS_WR;
                    end else if (w_expired) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end

                S_BUS_WR: begin
                    r_txd   <= c_rsp_ack;
                    r_state <= S_SEND;
                end

                S_BUS_RD: begin
                    r_state <= S_BUS_CAP;
                end

                S_BUS_CAP: begin
                    r_txd   <= bus_rdata_i;
                    r_state <= S_SEND;
                end

                S_SEND: begin
                    if (!tx_active_i) begin
                        r_state <= S_WAIT_TX;
                    end
                end

                S_WAIT_TX: begin
                    if (tx_done_tick_i) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode the registered state, so they fall to 0 with the
    // asynchronous reset and last exactly one cycle per visit.
    assign bus_we_o       = (r_state == S_BUS_WR);
    assign bus_re_o       = (r_state == S_BUS_RD);
    assign tx_start_o     = (r_state == S_SEND) && !tx_active_i;
    assign tx_din_o       = r_txd;
    assign bus_addr_o     = r_addr;
    assign bus_wdata_o    = r_wdata;
    assign timeout_tick_o = r_timeout;
    assign overrun_o      = r_overrun;
    assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_uart_cmd_responder.sv
module tb_uart_cmd_responder;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] rx_dout;
  logic       rx_done;
  logic [7:0] tx_din;
  logic       tx_start;
  logic       tx_active;
  logic       tx_done;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       timeout_tick;
  logic       overrun;
  logic [2:0] dbg_state;

  logic       tx_busy;
  logic       hold_active;

  assign tx_active = tx_busy | hold_active;

  uart_cmd_responder dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .rx_dout_i      (rx_dout),
    .rx_done_tick_i (rx_done),
    .tx_din_o       (tx_din),
    .tx_start_o     (tx_start),
    .tx_active_i    (tx_active),
    .tx_done_tick_i (tx_done),
    .bus_addr_o     (bus_addr),
    .bus_wdata_o    (bus_wdata),
    .bus_we_o       (bus_we),
    .bus_re_o       (bus_re),
    .bus_rdata_i    (bus_rdata),
    .timeout_tick_o (timeout_tick),
    .overrun_o      (overrun),
    .dbg_state_o    (dbg_state)
  );

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [7:0]  exp_q[$];          // response bytes, in order
  int          exp_start_cyc_q[$];
  logic [15:0] exp_we_q[$];       // {addr, data}
  int          exp_we_cyc_q[$];
  logic [7:0]  exp_re_q[$];       // read address
  int          exp_re_cyc_q[$];
  int          exp_to_cyc_q[$];
  logic        exp_overrun;

  // Reference register file: what a host would expect to read back.
  logic [7:0]  model_mem[256];
  // Bus slave seen by the DUT.
  logic [7:0]  slave_mem[256];

  function automatic logic [7:0] init_val(input int i);
    logic [7:0] a;
    a = 8'(i);
    return a ^ 8'h4A;
  endfunction

  // Monitor: every DUT output event pops one expectation.
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (tx_start) begin
        if (exp_q.size() == 0) check("unexpected_tx_start", 1, 0);
        else begin
          check("tx_din", tx_din, exp_q.pop_front());
          check("tx_start_cycle", cyc, exp_start_cyc_q.pop_front());
        end
      end
      if (bus_we) begin
        if (exp_we_q.size() == 0) check("unexpected_bus_we", 1, 0);
        else begin
          check("bus_we_addr_data", {bus_addr, bus_wdata}, exp_we_q.pop_front());
          check("bus_we_cycle", cyc, exp_we_cyc_q.pop_front());
        end
      end
      if (bus_re) begin
        if (exp_re_q.size() == 0) check("unexpected_bus_re", 1, 0);
        else begin
          check("bus_re_addr", bus_addr, exp_re_q.pop_front());
          check("bus_re_cycle", cyc, exp_re_cyc_q.pop_front());
        end
      end
      if (timeout_tick) begin
        if (exp_to_cyc_q.size() == 0) check("unexpected_timeout", 1, 0);
        else check("timeout_cycle", cyc, exp_to_cyc_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------- environment
  // Bus slave: sample strobes mid-cycle, update after the next edge so read
  // data is present in the cycle after bus_re.
  initial begin
    logic       we_s, re_s;
    logic [7:0] a_s, d_s;
    for (int i = 0; i < 256; i++) slave_mem[i] = init_val(i);
    bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      we_s = bus_we; re_s = bus_re; a_s = bus_addr; d_s = bus_wdata;
      @(posedge clk);
      #1;
      if (we_s) slave_mem[a_s] = d_s;
      if (re_s) bus_rdata = slave_mem[a_s];
    end
  end

  // Transmitter: busy for 20 cycles after a start, then a done tick.
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        tx_busy = 1'b0;
        tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  int last_tick;

  task automatic byte_on(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_dout   = b;
    rx_done   = 1'b1;
    last_tick = cyc;
  endtask

  task automatic byte_off(input int gap);
    @(posedge clk);
    #1 rx_done = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 2000 && !(dbg_state == 3'd0 && !tx_busy && !tx_done)) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", (n < 2000), 1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gap);
    byte_on(8'h57); byte_off(gap);
    byte_on(a);     byte_off(gap);
    byte_on(d);
    exp_we_q.push_back({a, d}); exp_we_cyc_q.push_back(last_tick + 1);
    exp_q.push_back(8'h06);     exp_start_cyc_q.push_back(last_tick + 2);
    model_mem[a] = d;
    byte_off(0);
    wait_idle();
  endtask

  task automatic do_read(input logic [7:0] a, input int gap);
    byte_on(8'h52); byte_off(gap);
    byte_on(a);
    exp_re_q.push_back(a);         exp_re_cyc_q.push_back(last_tick + 1);
    exp_q.push_back(model_mem[a]); exp_start_cyc_q.push_back(last_tick + 3);
    byte_off(0);
    wait_idle();
  endtask

  task automatic do_nak(input logic [7:0] b);
    byte_on(b);
    exp_q.push_back(8'h15); exp_start_cyc_q.push_back(last_tick + 1);
    byte_off(0);
    wait_idle();
  endtask

  task automatic reset_and_check(input string tag);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check({tag, "_outputs_zero"},
          {tx_din, tx_start, bus_addr, bus_wdata, bus_we, bus_re, timeout_tick, overrun}, 0);
    check({tag, "_state_idle"}, dbg_state, 0);
    exp_overrun = 1'b0;
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
  endtask

  task automatic wait_tx_busy();
    int n = 0;
    while (n < 100 && !tx_busy) begin
      @(negedge clk);
      n++;
    end
    check("tx_busy_seen", tx_busy, 1);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    logic [7:0] held;
    logic [7:0] b;
    rstn = 1'b0; rx_dout = 8'h00; rx_done = 1'b0; hold_active = 1'b0;
    exp_overrun = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_zero",
          {tx_din, tx_start, bus_addr, bus_wdata, bus_we, bus_re, timeout_tick, overrun}, 0);
    check("reset_state_idle", dbg_state, 0);
    #2 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Directed write, read, read-after-write, unknown commands.
    do_write(8'h3C, 8'hA5, 100);
    do_read(8'h10, 100);
    do_read(8'h3C, 7);
    do_nak(8'h00);
    do_nak(8'hFF);

    // Timeout after 'W', addr; then a normal read.
    byte_on(8'h57); byte_off(5);
    byte_on(8'h01);
    exp_to_cyc_q.push_back(last_tick + 440);
    byte_off(0);
    repeat (470) @(posedge clk);
    #1;
    check("timeout_consumed", exp_to_cyc_q.size(), 0);
    check("timeout_state_idle", dbg_state, 0);
    do_read(8'h01, 20);

    // Busy transmitter delays the NAK start until tx_active falls.
    hold_active = 1'b1;
    byte_on(8'h41);
    exp_q.push_back(8'h15); exp_start_cyc_q.push_back(last_tick + 50);
    @(posedge clk);
    #1 rx_done = 1'b0;
    repeat (49) @(posedge clk);
    #1 hold_active = 1'b0;

    // A byte during WAIT_TX is dropped and flagged.
    wait_tx_busy();
    held = tx_din;
    byte_on(8'h52);
    byte_off(0);
    exp_overrun = 1'b1;
    @(negedge clk);
    check("overrun_set", overrun, exp_overrun);
    check("tx_din_unchanged", tx_din, held);
    wait_idle();
    repeat (10) @(posedge clk);
    #1;
    check("dropped_byte_no_cmd", dbg_state, 0);
    check("overrun_sticky", overrun, exp_overrun);

    // Reset in GET_DATA, then in WAIT_TX.
    byte_on(8'h57); byte_off(3);
    byte_on(8'h22); byte_off(5);
    reset_and_check("rst_get_data");
    repeat (3) @(posedge clk);
    do_nak(8'h33);
    byte_on(8'h34);
    exp_q.push_back(8'h15); exp_start_cyc_q.push_back(last_tick + 1);
    byte_off(0);
    wait_tx_busy();
    reset_and_check("rst_wait_tx");
    repeat (40) @(posedge clk);
    do_write(8'h3C, 8'h5E, 10);
    do_read(8'h3C, 10);

    // Randomized commands against the reference model.
    for (int k = 0; k < 40; k++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0) do_write(8'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 150));
      else if (kind == 1) do_read(8'($urandom_range(0, 7)), $urandom_range(0, 150));
      else begin
        b = 8'($urandom);
        while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
        do_nak(b);
      end
    end

    repeat (10) @(posedge clk);
    #1;
    check("rsp_queue_empty", exp_q.size(), 0);
    check("we_queue_empty", exp_we_q.size(), 0);
    check("re_queue_empty", exp_re_q.size(), 0);
    check("overrun_final", overrun, exp_overrun);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
